vec_loop_ctrl: RTL and testbench

Sequencing controller for the element-wise vector datapath. It walks index i from 0 to len-1, fetches a[i], b[i] and (in mode 1) c[i] from a shared word-addressed memory port, and drives the datapath load/mul/add/store enables and selects. It then writes the datapath result back to c[i]. It sits directly upstream of the datapath: every datapath control input comes from this block. The memory read data bus feeds the datapath a/b/c data inputs, and the datapath result drives the memory write data.

---
 rtl/vec_loop_ctrl_if.sv | 39 +++
 rtl/vec_loop_ctrl.sv | 148 ++++++++++++++
 tb/tb_vec_loop_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_loop_ctrl_if.sv
// Job control, memory port and datapath control bundle for vec_loop_ctrl.
// master = the controller; slave = job issuer, memory and datapath side.
interface vec_loop_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              mode;
    logic [CNT_W-1:0]  len;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;
    logic              busy;
    logic              done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              load_a_en;
    logic              load_b_en;
    logic              load_c_en;
    logic              store_c_en;
    logic              mul_en;
    logic              add_en;
    logic [1:0]        mul_sel;
    logic [1:0]        add_sel;

    modport master (
        input  start, mode, len, base_a, base_b, base_c, mem_gnt,
        output busy, done, mem_req, mem_we, mem_addr,
        output load_a_en, load_b_en, load_c_en, store_c_en, mul_en, add_en, mul_sel, add_sel
    );

    modport slave (
        output start, mode, len, base_a, base_b, base_c, mem_gnt,
        input  busy, done, mem_req, mem_we, mem_addr,
        input  load_a_en, load_b_en, load_c_en, store_c_en, mul_en, add_en, mul_sel, add_sel
    );
endinterface

// File: rtl/vec_loop_ctrl.sv
// Element-wise vector loop sequencer: 6 (mode 0) / 8 (mode 1) cycles per element with
// mem_gnt held high; every mem_gnt=0 cycle stalls the request state with address held.
module vec_loop_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    vec_loop_ctrl_if.master   vl_if
);

    typedef enum logic [3:0] {
        IDLE, RD_A, RD_B, RD_C, LDW, MUL, ADD, MUL2, WR, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  i_q, i_d;
    logic              mode_q;
    logic [CNT_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;
    logic              pend_a_q, pend_b_q, pend_c_q;
    logic              pend_a_d, pend_b_d, pend_c_d;

    logic              mem_req_o, mem_we_o, store_c_en_o, mul_en_o, add_en_o, done_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [1:0]        mul_sel_o, add_sel_o;
    logic [CNT_W-1:0]  i_inc;

    assign i_inc = i_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            pend_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            pend_c_q <= pend_c_d;
            if (state_q == IDLE && vl_if.start) begin
                mode_q   <= vl_if.mode;
                len_q    <= vl_if.len;
                base_a_q <= vl_if.base_a;
                base_b_q <= vl_if.base_b;
                base_c_q <= vl_if.base_c;
            end
        end
    end

    // A granted read lands on the bus next cycle, so its load enable is just the delayed grant.
    assign pend_a_d = (state_q == RD_A) && vl_if.mem_gnt;
    assign pend_b_d = (state_q == RD_B) && vl_if.mem_gnt;
    assign pend_c_d = (state_q == RD_C) && vl_if.mem_gnt;

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        store_c_en_o = 1'b0;
        mul_en_o     = 1'b0;
        add_en_o     = 1'b0;
        mul_sel_o    = 2'b00;
        add_sel_o    = 2'b00;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (vl_if.start) begin
                    i_d     = '0;
                    state_d = (vl_if.len == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_a_q + ADDR_W'(i_q);
                if (vl_if.mem_gnt) state_d = RD_B;
            end
            RD_B: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_b_q + ADDR_W'(i_q);
                if (vl_if.mem_gnt) state_d = mode_q ? RD_C : LDW;
            end
            RD_C: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_c_q + ADDR_W'(i_q);
                if (vl_if.mem_gnt) state_d = LDW;
            end
            LDW: state_d = MUL;
            MUL: begin
                mul_en_o  = 1'b1;
                mul_sel_o = mode_q ? 2'b10 : 2'b01;
                state_d   = ADD;
            end
            ADD: begin
                add_en_o  = 1'b1;
                add_sel_o = mode_q ? 2'b10 : 2'b01;
                state_d   = mode_q ? MUL2 : WR;
            end
            MUL2: begin
                mul_en_o  = 1'b1;
                mul_sel_o = 2'b11;
                state_d   = WR;
            end
            WR: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = base_c_q + ADDR_W'(i_q);
                store_c_en_o = 1'b1;
                // Keep the c*sum product selected so the write data stays valid across stalls.
                mul_sel_o    = mode_q ? 2'b11 : 2'b00;
                if (vl_if.mem_gnt) begin
                    i_d     = i_inc;
                    state_d = (i_inc == len_q) ? DONE : RD_A;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign vl_if.busy       = (state_q != IDLE);
    assign vl_if.done       = done_o;
    assign vl_if.mem_req    = mem_req_o;
    assign vl_if.mem_we     = mem_we_o;
    assign vl_if.mem_addr   = mem_addr_o;
    assign vl_if.load_a_en  = pend_a_q;
    assign vl_if.load_b_en  = pend_b_q;
    assign vl_if.load_c_en  = pend_c_q;
    assign vl_if.store_c_en = store_c_en_o;
    assign vl_if.mul_en     = mul_en_o;
    assign vl_if.add_en     = add_en_o;
    assign vl_if.mul_sel    = mul_sel_o;
    assign vl_if.add_sel    = add_sel_o;

endmodule

// File: tb/tb_vec_loop_ctrl.sv
// Bench for vec_loop_ctrl: memory + datapath model driven by the DUT controls, with a
// write scoreboard filled from the arithmetic definition when each job is issued.
module tb_vec_loop_ctrl;
    logic clk = 1'b0;
    logic rst;

    vec_loop_ctrl_if #(.ADDR_W(16), .CNT_W(16)) vif ();

    vec_loop_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .vl_if (vif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int c0 = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int wr_first = -1;
    int req_cnt = 0;
    logic job_mode = 1'b0;
    bit stall_en = 1'b0;

    logic [15:0] mem [0:65535];
    logic [15:0] rdata, ra, rb, rc, rm, rres;
    logic [31:0] sb_q [$];
    logic [15:0] rd_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Grant driver: always-grant, or random stalls when stall_en is set.
    initial begin
        vif.mem_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            vif.mem_gnt = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Memory and datapath model, plus protocol checks, sampled mid-cycle.
    initial begin
        int          nload;
        logic        prev_rdg, prev_req, prev_gnt, prev_we, prev_st;
        logic [15:0] prev_addr;
        logic [31:0] e;
        prev_rdg = 0; prev_req = 0; prev_gnt = 0; prev_we = 0; prev_st = 0; prev_addr = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_rdg = 0; prev_req = 0; prev_gnt = 0;
                continue;
            end
            nload = int'(vif.load_a_en) + int'(vif.load_b_en) + int'(vif.load_c_en);
            if (prev_rdg || nload != 0) chk_eq("load_pulse", nload, prev_rdg ? 1 : 0);
            if (vif.load_a_en) ra = rdata;
            if (vif.load_b_en) rb = rdata;
            if (vif.load_c_en) rc = rdata;
            if (vif.mul_en) begin
                case (vif.mul_sel)
                    2'b01: rm = rb * 16'd2;
                    2'b10: rm = rb * 16'd5;
                    2'b11: rres = rc * rres;
                    default: ;
                endcase
            end
            if (vif.add_en) begin
                chk_eq("add_sel", vif.add_sel, job_mode ? 2'b10 : 2'b01);
                rres = ra + rm;
            end
            if (prev_req && !prev_gnt) begin
                chk_eq("stall_addr", vif.mem_addr, prev_addr);
                chk_eq("stall_ctl", {vif.mem_req, vif.mem_we, vif.store_c_en}, {1'b1, prev_we, prev_st});
            end
            if (vif.mem_req) begin
                req_cnt++;
                if (vif.mem_we) begin
                    if (wr_first < 0) wr_first = cyc - c0;
                    chk_eq("wr_ctl", {vif.store_c_en, vif.mul_en, vif.mul_sel},
                           {1'b1, 1'b0, (job_mode ? 2'b11 : 2'b00)});
                    if (vif.mem_gnt) begin
                        if (sb_q.size() == 0) chk_eq("sb_unexpected_wr", sb_q.size(), 1);
                        else begin
                            e = sb_q.pop_front();
                            chk_eq("wr_addr", vif.mem_addr, e[31:16]);
                            chk_eq("wr_data", rres, e[15:0]);
                        end
                        mem[vif.mem_addr] = rres;
                    end
                end else if (vif.mem_gnt) begin
                    rdata = mem[vif.mem_addr];
                    rd_log.push_back(vif.mem_addr);
                end
            end
            if (vif.done) begin
                done_cnt++;
                done_cyc = cyc - c0;
            end
            prev_rdg  = vif.mem_req && vif.mem_gnt && !vif.mem_we;
            prev_req  = vif.mem_req;
            prev_gnt  = vif.mem_gnt;
            prev_we   = vif.mem_we;
            prev_st   = vif.store_c_en;
            prev_addr = vif.mem_addr;
        end
    end

    task automatic push_exp(input logic m, input logic [15:0] n, input logic [15:0] ba,
                            input logic [15:0] bb, input logic [15:0] bc);
        logic [15:0] a, b, c, r;
        for (int k = 0; k < int'(n); k++) begin
            a = mem[ba + 16'(k)];
            b = mem[bb + 16'(k)];
            c = mem[bc + 16'(k)];
            r = m ? 16'(c * 16'(a + 16'(b * 16'd5))) : 16'(a + 16'(b * 16'd2));
            sb_q.push_back({16'(bc + 16'(k)), r});
        end
    endtask

    task automatic kick(input logic m, input logic [15:0] n, input logic [15:0] ba,
                        input logic [15:0] bb, input logic [15:0] bc);
        @(posedge clk);
        #1;
        vif.mode = m; vif.len = n;
        vif.base_a = ba; vif.base_b = bb; vif.base_c = bc;
        vif.start = 1'b1;
        c0 = cyc; job_mode = m; done_cyc = -1; wr_first = -1; req_cnt = 0;
        @(posedge clk);
        #1;
        vif.start = 1'b0;
    endtask

    task automatic wait_done(input int exp_done, input int spur_at);
        int d0;
        int t;
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < 2000) begin
            @(negedge clk);
            #2;
            t++;
            if (spur_at >= 0 && cyc - c0 == spur_at) begin
                vif.start = 1'b1;
                vif.len = 16'd7;
            end else vif.start = 1'b0;
        end
        chk_eq("done_seen", done_cnt - d0, 1);
        if (exp_done >= 0) chk_eq("done_cycle", done_cyc, exp_done);
        @(negedge clk);
        chk_eq("busy_after_done", vif.busy, 1'b0);
        chk_eq("sb_drained", sb_q.size(), 0);
    endtask

    task automatic run_job(input logic m, input logic [15:0] n, input logic [15:0] ba,
                           input logic [15:0] bb, input logic [15:0] bc,
                           input int exp_done, input int spur_at);
        push_exp(m, n, ba, bb, bc);
        kick(m, n, ba, bb, bc);
        wait_done(exp_done, spur_at);
    endtask

    initial begin
        logic [15:0] r0 [4];
        bit found;
        int d0;
        rst = 1'b1;
        vif.start = 1'b0; vif.mode = 1'b0; vif.len = '0;
        vif.base_a = '0; vif.base_b = '0; vif.base_c = '0;
        for (int k = 0; k < 65536; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy_done", {vif.busy, vif.done}, 2'b00);
        chk_eq("rst_mem", {vif.mem_req, vif.mem_we, vif.mem_addr}, 18'd0);
        chk_eq("rst_dp", {vif.load_a_en, vif.load_b_en, vif.load_c_en, vif.store_c_en,
                          vif.mul_en, vif.add_en, vif.mul_sel, vif.add_sel}, 10'd0);
        rst = 1'b0;

        // Mode 0, single element 3 + 2*4 = 11.
        mem[16'h0100] = 16'd3; mem[16'h0200] = 16'd4;
        run_job(1'b0, 16'd1, 16'h0100, 16'h0200, 16'h0300, 7, -1);
        chk_eq("t1_wr_cycle", wr_first, 6);
        chk_eq("t1_mem", mem[16'h0300], 16'd11);

        // Mode 1, three elements: c*(a+5b).
        for (int k = 0; k < 3; k++) begin
            mem[16'h1000 + 16'(k)] = 16'(k + 1);
            mem[16'h2000 + 16'(k)] = 16'd1;
            mem[16'h3000 + 16'(k)] = 16'(k + 2);
        end
        run_job(1'b1, 16'd3, 16'h1000, 16'h2000, 16'h3000, 25, -1);
        chk_eq("t2_c0", mem[16'h3000], 16'd12);
        chk_eq("t2_c1", mem[16'h3001], 16'd21);
        chk_eq("t2_c2", mem[16'h3002], 16'd32);

        // Empty job.
        run_job(1'b0, 16'd0, 16'h4000, 16'h4100, 16'h4200, 1, -1);
        chk_eq("t3_no_req", req_cnt, 0);

        // Same data with and without grant stalls.
        for (int k = 0; k < 4; k++) begin
            mem[16'h5000 + 16'(k)] = 16'($urandom_range(0, 999));
            mem[16'h6000 + 16'(k)] = 16'($urandom_range(0, 999));
        end
        run_job(1'b0, 16'd4, 16'h5000, 16'h6000, 16'h7000, 25, -1);
        for (int k = 0; k < 4; k++) r0[k] = mem[16'h7000 + 16'(k)];
        stall_en = 1'b1;
        run_job(1'b0, 16'd4, 16'h5000, 16'h6000, 16'h7100, -1, -1);
        stall_en = 1'b0;
        for (int k = 0; k < 4; k++) chk_eq("t4_stall_eq", mem[16'h7100 + 16'(k)], r0[k]);

        // Reset during the write of element 2, then a clean restart.
        for (int k = 0; k < 4; k++) begin
            mem[16'h8000 + 16'(k)] = 16'(10 * k + 1);
            mem[16'h8100 + 16'(k)] = 16'(k + 3);
        end
        push_exp(1'b0, 16'd4, 16'h8000, 16'h8100, 16'h8200);
        kick(1'b0, 16'd4, 16'h8000, 16'h8100, 16'h8200);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            #2;
            if (vif.mem_req && vif.mem_we && vif.mem_addr == 16'h8202) found = 1'b1;
        end
        chk_eq("t5_wr2_seen", found, 1'b1);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk_eq("t5_rst_busy_done", {vif.busy, vif.done}, 2'b00);
        chk_eq("t5_rst_mem", {vif.mem_req, vif.mem_we, vif.mem_addr}, 18'd0);
        chk_eq("t5_rst_dp", {vif.load_a_en, vif.load_b_en, vif.load_c_en, vif.store_c_en,
                             vif.mul_en, vif.add_en, vif.mul_sel, vif.add_sel}, 10'd0);
        #2;
        rst = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        chk_eq("t5_no_done", done_cnt - d0, 0);
        run_job(1'b0, 16'd2, 16'h8000, 16'h8100, 16'h8300, 13, -1);

        // Address wrap on base_a, with a start pulse while busy.
        mem[16'hFFFF] = 16'd10; mem[16'h0000] = 16'd20;
        mem[16'h9000] = 16'd1;  mem[16'h9001] = 16'd2;
        rd_log.delete();
        run_job(1'b0, 16'd2, 16'hFFFF, 16'h9000, 16'h9100, 13, 5);
        if (rd_log.size() >= 3) begin
            chk_eq("t6_rd_a0", rd_log[0], 16'hFFFF);
            chk_eq("t6_rd_a1", rd_log[2], 16'h0000);
        end else chk_eq("t6_rd_count", rd_log.size(), 4);
        chk_eq("t6_c0", mem[16'h9100], 16'd12);
        chk_eq("t6_c1", mem[16'h9101], 16'd24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
